// File: rtl/keccak_req_arbiter.sv
// Round-robin arbiter sharing one keccak_core between NUM_REQ hashing clients.
// Optional squeeze watchdog enabled by defining KECCAK_ARB_TIMEOUT_EN.
module keccak_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DWIDTH         = 64,
  parameter int KEEP_WIDTH     = 8,
  parameter int OUT_DWIDTH     = 256,
  parameter int MODE_W         = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*MODE_W-1:0]      mode_i,
  input  logic [NUM_REQ-1:0]             stop_i,
  output logic [NUM_REQ-1:0]             grant_o,
  input  logic [NUM_REQ*DWIDTH-1:0]      s_data_i,
  input  logic [NUM_REQ-1:0]             s_valid_i,
  input  logic [NUM_REQ-1:0]             s_last_i,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]  s_keep_i,
  output logic [NUM_REQ-1:0]             s_ready_o,
  output logic [OUT_DWIDTH-1:0]          m_data_o,
  output logic [KEEP_WIDTH-1:0]          m_keep_o,
  output logic                           m_last_o,
  output logic [NUM_REQ-1:0]             m_valid_o,
  input  logic [NUM_REQ-1:0]             m_ready_i,
  output logic                           core_start_o,
  output logic [MODE_W-1:0]              core_mode_o,
  output logic                           core_stop_o,
  output logic [DWIDTH-1:0]              core_data_o,
  output logic                           core_valid_o,
  output logic                           core_last_o,
  output logic [KEEP_WIDTH-1:0]          core_keep_o,
  input  logic                           core_ready_i,
  input  logic [OUT_DWIDTH-1:0]          core_data_i,
  input  logic [KEEP_WIDTH-1:0]          core_keep_i,
  input  logic                           core_last_i,
  input  logic                           core_valid_i,
  output logic                           core_out_ready_o,
  output logic                           busy_o,
  output logic                           err_timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_ABSORB  = 3'd2;
  localparam logic [2:0] S_SQUEEZE = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("keccak_req_arbiter: unsupported parameter set");
  end

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [IDX_W-1:0]   sel, cand;

  logic absorb, squeeze;
  logic g_valid, g_last, g_stop, g_mready;
  logic out_xfer, timeout_hit;

  assign absorb   = (state_q == S_ABSORB);
  assign squeeze  = (state_q == S_SQUEEZE);
  assign g_valid  = s_valid_i[owner_q];
  assign g_last   = s_last_i[owner_q];
  assign g_stop   = stop_i[owner_q];
  assign g_mready = m_ready_i[owner_q];

  // Walk from the highest offset down so the last hit is the first request at/after ptr_q.
  always_comb begin
    sel  = ptr_q;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (req_i[cand]) sel = cand;
    end
  end

  always_comb begin
    core_data_o      = absorb ? s_data_i[int'(owner_q)*DWIDTH +: DWIDTH] : '0;
    core_keep_o      = absorb ? s_keep_i[int'(owner_q)*KEEP_WIDTH +: KEEP_WIDTH] : '0;
    core_valid_o     = absorb & g_valid;
    core_last_o      = absorb & g_last;
    s_ready_o        = absorb ? (grant_q & {NUM_REQ{core_ready_i}}) : '0;
    m_data_o         = core_data_i;
    m_keep_o         = core_keep_i;
    m_last_o         = squeeze & core_last_i;
    m_valid_o        = squeeze ? (grant_q & {NUM_REQ{core_valid_i}}) : '0;
    core_out_ready_o = squeeze & g_mready & ~g_stop;
    core_start_o     = (state_q == S_START);
    core_stop_o      = squeeze & (g_stop | timeout_hit);
    err_timeout_o    = squeeze & ~g_stop & timeout_hit;
    busy_o           = (state_q != S_IDLE);
    grant_o          = grant_q;
    core_mode_o      = mode_q;
  end

  assign out_xfer = core_valid_i & core_out_ready_o;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          mode_d       = mode_i[int'(sel)*MODE_W +: MODE_W];
          state_d      = S_START;
        end
      end
      S_START: state_d = S_ABSORB;
      S_ABSORB: begin
        if (g_valid & core_ready_i & g_last) state_d = S_SQUEEZE;
      end
      S_SQUEEZE: begin
        // A stop request wins over a coinciding last beat; out_xfer is already blocked by it.
        if (g_stop | timeout_hit | (out_xfer & core_last_i)) begin
          state_d = S_RELEASE;
          grant_d = '0;
          ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
    end
  end

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            stall;

  assign stall       = squeeze & core_valid_i & ~g_mready;
  assign timeout_hit = stall & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside SQUEEZE, so every squeeze phase starts fresh.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!squeeze)      to_cnt_d = '0;
    else if (out_xfer) to_cnt_d = '0;
    else if (stall)    to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_req_arbiter.sv
// Directed bench for keccak_req_arbiter: a vector table for owner steering plus
// hand-written sequences for sessions, rotation, stop, reset and the watchdog.
module tb_keccak_req_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_i, stop_i, s_valid_i, s_last_i, m_ready_i;
  logic [7:0]    mode_i;
  logic [3:0]    grant_o, s_ready_o, m_valid_o;
  logic [255:0]  s_data_i;
  logic [31:0]   s_keep_i;
  logic [255:0]  m_data_o, core_data_i;
  logic [7:0]    m_keep_o, core_keep_o, core_keep_i;
  logic          m_last_o, core_start_o, core_stop_o, core_valid_o, core_last_o;
  logic [1:0]    core_mode_o;
  logic [63:0]   core_data_o;
  logic          core_ready_i, core_last_i, core_valid_i, core_out_ready_o;
  logic          busy_o, err_timeout_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] sv;
    logic       cr;
    logic [3:0] exp_sr;
    logic       exp_cv;
  } vec_t;

  vec_t       vecs [7];
  logic [1:0] mode_tab [4];

  keccak_req_arbiter #(
    .NUM_REQ(4), .DWIDTH(64), .KEEP_WIDTH(8), .OUT_DWIDTH(256),
    .MODE_W(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .mode_i(mode_i), .stop_i(stop_i), .grant_o(grant_o),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
    .s_keep_i(s_keep_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .core_start_o(core_start_o), .core_mode_o(core_mode_o), .core_stop_o(core_stop_o),
    .core_data_o(core_data_o), .core_valid_o(core_valid_o), .core_last_o(core_last_o),
    .core_keep_o(core_keep_o), .core_ready_i(core_ready_i),
    .core_data_i(core_data_i), .core_keep_i(core_keep_i), .core_last_i(core_last_i),
    .core_valid_i(core_valid_i), .core_out_ready_o(core_out_ready_o),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_i = '0; stop_i = '0; s_valid_i = '0; s_last_i = '0; m_ready_i = '0;
    core_ready_i = 1'b0; core_last_i = 1'b0; core_valid_i = 1'b0;
    core_data_i = '0; core_keep_i = '0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (core_start_o) break;
      step();
    end
    chk("start_seen", core_start_o, 1);
  endtask

  // One full minimal session for client c: start, one-beat message, one-beat digest.
  task automatic do_session(input int c);
    logic [3:0] oh;
    oh = 4'(1 << c);
    wait_start();
    chk("sess_grant", grant_o, oh);
    chk("sess_mode", core_mode_o, mode_tab[c]);
    step();
    chk("sess_start_single", core_start_o, 0);
    s_valid_i = oh; s_last_i = oh; core_ready_i = 1'b1;
    #1;
    chk("sess_s_ready", s_ready_o, oh);
    chk("sess_core_valid", core_valid_o, 1);
    step();
    s_valid_i = '0; s_last_i = '0; core_ready_i = 1'b0;
    core_valid_i = 1'b1; core_last_i = 1'b1; m_ready_i = 4'hF;
    #1;
    chk("sess_m_valid", m_valid_o, oh);
    chk("sess_m_last", m_last_o, 1);
    step();
    core_valid_i = 1'b0; core_last_i = 1'b0; m_ready_i = '0;
    #1;
    chk("sess_release_grant", grant_o, 0);
    chk("sess_release_busy", busy_o, 1);
    step();
    chk("sess_idle_busy", busy_o, 0);
  endtask

  initial begin
    int xfers;
    mode_tab[0] = 2'd1; mode_tab[1] = 2'd2; mode_tab[2] = 2'd3; mode_tab[3] = 2'd0;
    vecs[0] = '{sv: 4'b0001, cr: 1'b1, exp_sr: 4'b0010, exp_cv: 1'b0};
    vecs[1] = '{sv: 4'b0001, cr: 1'b0, exp_sr: 4'b0000, exp_cv: 1'b0};
    vecs[2] = '{sv: 4'b0011, cr: 1'b1, exp_sr: 4'b0010, exp_cv: 1'b1};
    vecs[3] = '{sv: 4'b0011, cr: 1'b0, exp_sr: 4'b0000, exp_cv: 1'b1};
    vecs[4] = '{sv: 4'b1111, cr: 1'b1, exp_sr: 4'b0010, exp_cv: 1'b1};
    vecs[5] = '{sv: 4'b1101, cr: 1'b1, exp_sr: 4'b0010, exp_cv: 1'b0};
    vecs[6] = '{sv: 4'b0010, cr: 1'b1, exp_sr: 4'b0010, exp_cv: 1'b1};

    clear_inputs();
    mode_i   = {mode_tab[3], mode_tab[2], mode_tab[1], mode_tab[0]};
    s_data_i = '0;
    s_keep_i = 32'hFFFF_FFFF;
    rst = 1'b1;
    step(); step();

    // Reset state
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_start", core_start_o, 0);
    chk("rst_mode", core_mode_o, 0);
    chk("rst_err", err_timeout_o, 0);
    chk("rst_s_ready", s_ready_o, 0);
    rst = 1'b0;
    step();

    // Single client 0 session, 3-beat message, one digest beat
    req_i = 4'b0001;
    step();
    chk("t1_grant", grant_o, 4'b0001);
    chk("t1_start", core_start_o, 1);
    chk("t1_mode", core_mode_o, 2'd1);
    chk("t1_busy", busy_o, 1);
    req_i = '0;
    step();
    chk("t1_start_off", core_start_o, 0);
    for (int b = 0; b < 3; b++) begin
      s_data_i[63:0] = 64'hA000 + 64'(b);
      s_valid_i = 4'b0001; s_last_i = (b == 2) ? 4'b0001 : 4'b0000; core_ready_i = 1'b1;
      #1;
      chk("t1_core_data", core_data_o, 64'hA000 + 64'(b));
      chk("t1_core_last", core_last_o, (b == 2));
      step();
    end
    s_valid_i = '0; s_last_i = '0; core_ready_i = 1'b0;
    core_valid_i = 1'b1; core_last_i = 1'b1; core_keep_i = 8'h0F;
    core_data_i = 256'h0123_4567_89AB_CDEF; m_ready_i = 4'b0001;
    #1;
    chk("t1_m_valid", m_valid_o, 4'b0001);
    chk("t1_m_data", m_data_o, 256'h0123_4567_89AB_CDEF);
    chk("t1_m_keep", m_keep_o, 8'h0F);
    chk("t1_out_ready", core_out_ready_o, 1);
    step();
    clear_inputs();
    #1;
    chk("t1_rel_busy", busy_o, 1);
    chk("t1_rel_grant", grant_o, 0);
    step();
    chk("t1_idle_busy", busy_o, 0);

    // Client 1 owns ABSORB while other clients present data: vector table
    req_i = 4'b0010;
    step();
    req_i = '0;
    chk("t4_grant", grant_o, 4'b0010);
    step();
    s_data_i = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
                64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    for (int i = 0; i < 7; i++) begin
      s_valid_i = vecs[i].sv; core_ready_i = vecs[i].cr; s_last_i = '0;
      #1;
      chk($sformatf("t4_s_ready[%0d]", i), s_ready_o, vecs[i].exp_sr);
      chk($sformatf("t4_core_valid[%0d]", i), core_valid_o, vecs[i].exp_cv);
      chk($sformatf("t4_core_data[%0d]", i), core_data_o, 64'hC1C1_0000_0000_0001);
      step();
    end

    // Asynchronous reset mid-ABSORB
    s_valid_i = 4'b1111; core_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5_grant", grant_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_start", core_start_o, 0);
    chk("t5_s_ready", s_ready_o, 0);
    chk("t5_core_valid", core_valid_o, 0);
    chk("t5_mode", core_mode_o, 0);
    step(); step();
    rst = 1'b0;
    clear_inputs();
    step();

    // All clients requesting: rotation from pointer 0 proves the pointer was reset
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_i = 4'b0001;
      do_session(k % 4);
    end
    req_i = '0;
    step();

    // Client 2 XOF: five beats, then stop coinciding with a last beat
    req_i = 4'b0100;
    step();
    chk("t3_grant", grant_o, 4'b0100);
    req_i = 4'b1110;
    step();
    s_valid_i = 4'b0100; s_last_i = 4'b0100; core_ready_i = 1'b1;
    step();
    s_valid_i = '0; s_last_i = '0; core_ready_i = 1'b0;
    core_valid_i = 1'b1; m_ready_i = 4'b0100;
    xfers = 0;
    for (int b = 0; b < 5; b++) begin
      core_data_i = 256'(b + 1);
      #1;
      if (m_valid_o[2] && core_out_ready_o) xfers++;
      step();
    end
    chk("t3_xfers", 32'(xfers), 5);
    stop_i = 4'b0100; core_last_i = 1'b1;
    #1;
    chk("t3_stop", core_stop_o, 1);
    chk("t3_no_sixth", core_out_ready_o, 0);
    chk("t3_err", err_timeout_o, 0);
    step();
    stop_i = '0; core_valid_i = 1'b0; core_last_i = 1'b0; m_ready_i = '0;
    #1;
    chk("t3_stop_once", core_stop_o, 0);
    chk("t3_rel_grant", grant_o, 0);
    step();
    chk("t3_idle_grant", grant_o, 0);
    step();
    chk("t3_next_grant", grant_o, 4'b1000);
    req_i = '0;
    do_session(3);
    step(); step();
    chk("t3_dropped_req", grant_o, 0);
    chk("t3_dropped_busy", busy_o, 0);

`ifdef KECCAK_ARB_TIMEOUT_EN
    // Watchdog: client 0 stalls the output for TIMEOUT_CYCLES cycles
    req_i = 4'b0001;
    step();
    req_i = '0;
    chk("t6_grant", grant_o, 4'b0001);
    step();
    s_valid_i = 4'b0001; s_last_i = 4'b0001; core_ready_i = 1'b1;
    step();
    s_valid_i = '0; s_last_i = '0; core_ready_i = 1'b0;
    core_valid_i = 1'b1; m_ready_i = '0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("t6_stop[%0d]", k), core_stop_o, (k == 16));
      chk($sformatf("t6_err[%0d]", k), err_timeout_o, (k == 16));
      if (k < 16) step();
    end
    step();
    core_valid_i = 1'b0;
    #1;
    chk("t6_rel_grant", grant_o, 0);
    chk("t6_rel_err", err_timeout_o, 0);
    step();
    chk("t6_idle_busy", busy_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
